axi_channel_reg_slice: RTL and testbench

AXI_CHANNEL_REG_SLICE -- requirements
Module: axi_channel_reg_slice

---
 rtl/axi_reg_slice_defs.vh | 10 +
 rtl/axi_channel_reg_slice.sv | 155 +++++++++++++++
 tb/tb_axi_channel_reg_slice.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/axi_reg_slice_defs.vh
// Handshake registering modes shared by axi_channel_reg_slice and its callers.
`ifndef AXI_REG_SLICE_DEFS_VH
`define AXI_REG_SLICE_DEFS_VH

`define AXI_RS_BYPASS 0
`define AXI_RS_FWD    1
`define AXI_RS_REV    2
`define AXI_RS_FULL   3

`endif

// File: rtl/axi_channel_reg_slice.sv
// Single AXI channel register slice; HNDSHK_MODE picks which handshake
// directions are registered (bypass, forward, reverse or full skid buffer).
`timescale 1ns/1ps
`include "axi_reg_slice_defs.vh"

module axi_channel_reg_slice #(
  parameter int unsigned HNDSHK_MODE = `AXI_RS_FULL,
  parameter int unsigned PAYLD_WIDTH = 64
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   valid_src,
  input  logic [PAYLD_WIDTH-1:0] payload_src,
  output logic                   ready_src,
  output logic                   valid_dst,
  output logic [PAYLD_WIDTH-1:0] payload_dst,
  input  logic                   ready_dst
);

  generate
    if (HNDSHK_MODE == `AXI_RS_FULL) begin : g_full
      logic                   main_valid, main_valid_nxt;
      logic                   skid_valid, skid_valid_nxt;
      logic                   rdy_q;
      logic [PAYLD_WIDTH-1:0] main_data, main_data_nxt;
      logic [PAYLD_WIDTH-1:0] skid_data, skid_data_nxt;
      logic                   accept, drain;

      // Main register refills from skid first so ordering is preserved.
      always_comb begin
        accept         = valid_src & rdy_q;
        drain          = main_valid & ready_dst;
        main_valid_nxt = main_valid;
        main_data_nxt  = main_data;
        skid_valid_nxt = skid_valid;
        skid_data_nxt  = skid_data;
        if (!main_valid || drain) begin
          if (skid_valid) begin
            main_valid_nxt = 1'b1;
            main_data_nxt  = skid_data;
            skid_valid_nxt = accept;
            if (accept) skid_data_nxt = payload_src;
          end else begin
            main_valid_nxt = accept;
            if (accept) main_data_nxt = payload_src;
          end
        end else if (accept) begin
          skid_valid_nxt = 1'b1;
          skid_data_nxt  = payload_src;
        end
      end

      // rdy_q mirrors the next skid state so ready_src stays a flop output.
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
          rdy_q      <= 1'b0;
          main_data  <= '0;
          skid_data  <= '0;
        end else begin
          main_valid <= main_valid_nxt;
          skid_valid <= skid_valid_nxt;
          rdy_q      <= !skid_valid_nxt;
          main_data  <= main_data_nxt;
          skid_data  <= skid_data_nxt;
        end
      end

      assign ready_src   = rdy_q;
      assign valid_dst   = main_valid;
      assign payload_dst = main_data;

    end else if (HNDSHK_MODE == `AXI_RS_FWD) begin : g_fwd
      logic                   valid_q, valid_nxt;
      logic [PAYLD_WIDTH-1:0] data_q, data_nxt;
      logic                   rst_done;
      logic                   rdy_c;

      always_comb begin
        rdy_c     = rst_done & (ready_dst | ~valid_q);
        valid_nxt = valid_q;
        data_nxt  = data_q;
        if (rdy_c && valid_src) begin
          valid_nxt = 1'b1;
          data_nxt  = payload_src;
        end else if (ready_dst) begin
          valid_nxt = 1'b0;
        end
      end

      // rst_done holds ready_src low through reset and the edge it is released on.
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          valid_q  <= 1'b0;
          data_q   <= '0;
          rst_done <= 1'b0;
        end else begin
          valid_q  <= valid_nxt;
          data_q   <= data_nxt;
          rst_done <= 1'b1;
        end
      end

      assign ready_src   = rdy_c;
      assign valid_dst   = valid_q;
      assign payload_dst = data_q;

    end else if (HNDSHK_MODE == `AXI_RS_REV) begin : g_rev
      logic                   skid_valid, skid_valid_nxt;
      logic [PAYLD_WIDTH-1:0] skid_data, skid_data_nxt;
      logic                   rdy_q;
      logic                   accept;

      // Skid captures a beat only when it is accepted but not passed through.
      always_comb begin
        accept         = valid_src & rdy_q;
        skid_valid_nxt = skid_valid;
        skid_data_nxt  = skid_data;
        if (skid_valid) begin
          if (ready_dst) skid_valid_nxt = 1'b0;
        end else if (accept && !ready_dst) begin
          skid_valid_nxt = 1'b1;
          skid_data_nxt  = payload_src;
        end
      end

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          skid_valid <= 1'b0;
          skid_data  <= '0;
          rdy_q      <= 1'b0;
        end else begin
          skid_valid <= skid_valid_nxt;
          skid_data  <= skid_data_nxt;
          rdy_q      <= !skid_valid_nxt;
        end
      end

      // Gating pass-through valid with rdy_q keeps valid_dst low during reset.
      assign ready_src   = rdy_q;
      assign valid_dst   = skid_valid | (valid_src & rdy_q);
      assign payload_dst = skid_valid ? skid_data : payload_src;

    end else if (HNDSHK_MODE == `AXI_RS_BYPASS) begin : g_bypass
      assign ready_src   = ready_dst;
      assign valid_dst   = valid_src;
      assign payload_dst = payload_src;

    end else begin : g_illegal
      $error("axi_channel_reg_slice: illegal HNDSHK_MODE %0d", HNDSHK_MODE);
    end
  endgenerate

endmodule

// File: tb/tb_axi_channel_reg_slice.sv
// Directed and randomized checks of axi_channel_reg_slice in all four modes.
`timescale 1ns/1ps

module tb_axi_channel_reg_slice;

  localparam int unsigned PW     = 16;
  localparam int unsigned NITEMS = 1000;
  localparam int          FULL   = 3;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b0;
  logic [3:0]           vs, rs, vd, rd;
  logic [3:0][PW-1:0]   ps, pd;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    axi_channel_reg_slice #(
      .HNDSHK_MODE (g),
      .PAYLD_WIDTH (PW)
    ) u_dut (
      .aclk        (clk),
      .aresetn     (rst_n),
      .valid_src   (vs[g]),
      .payload_src (ps[g]),
      .ready_src   (rs[g]),
      .valid_dst   (vd[g]),
      .payload_dst (pd[g]),
      .ready_dst   (rd[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Random valid/ready traffic; payload i is the item index, checked in order.
  task automatic run_random(input int m);
    int unsigned     sent = 0;
    int unsigned     recv = 0;
    int unsigned     cyc  = 0;
    logic            stall = 1'b0;
    logic            acc   = 1'b0;
    logic [PW-1:0]   held  = '0;
    vs[m] = 1'b0;
    rd[m] = 1'b0;
    while (recv < NITEMS && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (stall) begin
        check($sformatf("m%0d hold valid", m), 32'(vd[m]), 32'd1);
        check($sformatf("m%0d hold payload", m), 32'(pd[m]), 32'(held));
      end
      if (acc) vs[m] = 1'b0;
      if (!vs[m] && sent < NITEMS && $urandom_range(0, 3) != 0) begin
        vs[m] = 1'b1;
        ps[m] = PW'(sent);
      end
      rd[m] = ($urandom_range(0, 3) != 0);
      #1;
      stall = vd[m] & ~rd[m];
      held  = pd[m];
      acc   = vs[m] & rs[m];
      if (vd[m] && rd[m]) begin
        check($sformatf("m%0d order item %0d", m, recv), 32'(pd[m]), 32'(PW'(recv)));
        recv++;
      end
      if (acc) sent++;
    end
    check($sformatf("m%0d items delivered", m), recv, NITEMS);
    @(negedge clk);
    vs[m] = 1'b0;
    rd[m] = 1'b1;
  endtask

  initial begin
    vs    = '0;
    rd    = '1;
    ps    = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state of the registered modes
    for (int m = 1; m < 4; m++) begin
      check($sformatf("m%0d reset ready_src", m), 32'(rs[m]), 32'd0);
      check($sformatf("m%0d reset valid_dst", m), 32'(vd[m]), 32'd0);
    end
    check("full reset payload", 32'(pd[FULL]), 32'd0);

    // First beat after reset release
    rst_n     = 1'b1;
    vs[FULL]  = 1'b1;
    ps[FULL]  = 16'h00A5;
    #1;
    check("ready before first edge", 32'(rs[FULL]), 32'd0);
    @(negedge clk);
    check("ready after first edge", 32'(rs[FULL]), 32'd1);
    check("valid before accept", 32'(vd[FULL]), 32'd0);
    @(negedge clk);
    check("first beat valid", 32'(vd[FULL]), 32'd1);
    check("first beat payload", 32'(pd[FULL]), 32'h00A5);
    vs[FULL] = 1'b0;
    @(negedge clk);
    check("first beat drained", 32'(vd[FULL]), 32'd0);

    // Full-rate stream 1..8
    for (int i = 1; i <= 9; i++) begin
      check($sformatf("stream ready %0d", i), 32'(rs[FULL]), 32'd1);
      if (i >= 2) begin
        check($sformatf("stream valid %0d", i), 32'(vd[FULL]), 32'd1);
        check($sformatf("stream data %0d", i), 32'(pd[FULL]), 32'(i - 1));
      end
      if (i <= 8) begin
        vs[FULL] = 1'b1;
        ps[FULL] = PW'(i);
      end else begin
        vs[FULL] = 1'b0;
      end
      @(negedge clk);
    end
    check("stream drained", 32'(vd[FULL]), 32'd0);

    // Backpressure: 1 to main, 2 to skid, 3 held upstream
    rd[FULL] = 1'b0;
    vs[FULL] = 1'b1;
    ps[FULL] = 16'd1;
    @(negedge clk);
    check("bp main valid", 32'(vd[FULL]), 32'd1);
    check("bp main data", 32'(pd[FULL]), 32'd1);
    check("bp ready one entry", 32'(rs[FULL]), 32'd1);
    ps[FULL] = 16'd2;
    @(negedge clk);
    check("bp ready full", 32'(rs[FULL]), 32'd0);
    check("bp head data", 32'(pd[FULL]), 32'd1);
    ps[FULL] = 16'd3;
    @(negedge clk);
    check("bp still full", 32'(rs[FULL]), 32'd0);
    check("bp hold valid", 32'(vd[FULL]), 32'd1);
    check("bp hold data", 32'(pd[FULL]), 32'd1);
    rd[FULL] = 1'b1;
    @(negedge clk);
    check("bp out 2", 32'(pd[FULL]), 32'd2);
    check("bp ready back", 32'(rs[FULL]), 32'd1);
    @(negedge clk);
    check("bp out 3 valid", 32'(vd[FULL]), 32'd1);
    check("bp out 3", 32'(pd[FULL]), 32'd3);
    vs[FULL] = 1'b0;
    @(negedge clk);
    check("bp drained", 32'(vd[FULL]), 32'd0);

    // Async reset while both entries are full
    rd[FULL] = 1'b0;
    vs[FULL] = 1'b1;
    ps[FULL] = 16'h0011;
    @(negedge clk);
    ps[FULL] = 16'h0022;
    @(negedge clk);
    vs[FULL] = 1'b0;
    check("pre-reset full", 32'(rs[FULL]), 32'd0);
    check("pre-reset valid", 32'(vd[FULL]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset valid", 32'(vd[FULL]), 32'd0);
    check("async reset ready", 32'(rs[FULL]), 32'd0);
    check("async reset payload", 32'(pd[FULL]), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    rd[FULL] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("no stale data %0d", i), 32'(vd[FULL]), 32'd0);
    end

    for (int m = 0; m < 4; m++) run_random(m);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
